wide_add_seq: RTL and testbench

Multi-cycle wide adder/subtractor sequencer. It time-shares one 16-bit ripple adder across `WORDS` 16-bit slices, chaining the carry through a register. It adds wide-operand support to the arithmetic datapath without replicating adder hardware. Operands enter and results leave on valid/ready handshakes, so the block sits between an operand source (register file / issue logic) and a result consumer.

---
 rtl/arith_pkg.sv | 5 +
 rtl/wide_add_seq_adder.sv | 19 +
 rtl/wide_add_seq.sv | 99 +++++++++
 tb/tb_wide_add_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: sequencer state encoding and adder slice width.
package arith_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int SLICE_W = 16;
endpackage

// File: rtl/wide_add_seq_adder.sv
// 16-bit ripple-carry full adder, time-shared by the wide sequencer.
module FullAdder_16bit
    import arith_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);
    logic [SLICE_W:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[SLICE_W];
endmodule

// File: rtl/wide_add_seq.sv
// Wide add/subtract that walks one 16-bit adder across WORDS slices,
// carrying between slices through a register.
module wide_add_seq
    import arith_pkg::*;
#(
    parameter int WORDS = 4,
    localparam int W    = SLICE_W * WORDS,
    localparam int IW   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         InValid,
    output logic         InReady,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
    input  logic         Sub,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [W-1:0] Sum,
    output logic         Cout,
    output logic         Overflow,
    output logic         Busy
);
    state_t state, state_nxt;

    logic [WORDS-1:0][SLICE_W-1:0] a_q, b_q, sum_q;
    logic [IW-1:0]      idx;
    logic               carry;
    logic               last;
    logic [SLICE_W-1:0] fa_sum;
    logic               fa_cout;

    assign last = (idx == IW'(WORDS - 1));

    FullAdder_16bit u_fa (
        .a    (a_q[idx]),
        .b    (b_q[idx]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (InValid)  state_nxt = RUN;
            RUN:     if (last)     state_nxt = DONE;
            DONE:    if (OutReady) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign InReady = (state == IDLE);
    assign Busy    = (state != IDLE);
    assign Sum     = sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
            OutValid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (InValid) begin
                    // Subtract is A + ~B + 1, so the operand is inverted once at accept.
                    a_q   <= A;
                    b_q   <= B ^ {W{Sub}};
                    carry <= Sub | Cin;
                    idx   <= '0;
                end
                RUN: begin
                    sum_q[idx] <= fa_sum;
                    carry      <= fa_cout;
                    if (last) begin
                        Cout     <= fa_cout;
                        Overflow <= (a_q[idx][SLICE_W-1] ~^ b_q[idx][SLICE_W-1]) &
                                    (fa_sum[SLICE_W-1] ^ a_q[idx][SLICE_W-1]);
                        OutValid <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: if (OutReady) OutValid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wide_add_seq.sv
// Scoreboard bench for wide_add_seq (WORDS=4): spec vectors, backpressure,
// mid-run reset and random add/sub against a behavioural model.
module tb_wide_add_seq;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         InValid = 1'b0;
    logic         OutReady = 1'b0;
    logic         Cin = 1'b0;
    logic         Sub = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         InReady, OutValid, Cout, Overflow, Busy;
    logic [W-1:0] Sum;

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    wide_add_seq #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub),
        .OutValid(OutValid), .OutReady(OutReady),
        .Sum(Sum), .Cout(Cout), .Overflow(Overflow), .Busy(Busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, b, input logic cin, sub);
        exp_t         e;
        logic [W-1:0] bp;
        logic [W:0]   full;
        bp     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] ~^ bp[W-1]) & (full[W-1] ^ a[W-1]);
        return e;
    endfunction

    // Waits for InReady, presents one request, pushes its expected result,
    // returns just after the accept edge with junk left on the operand bus.
    task automatic send(input logic [W-1:0] a, b, input logic cin, sub, input exp_t e);
        int n;
        @(negedge clk);
        n = 0;
        while (!InReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!InReady) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_wait: InReady=%b required 1 within 50 cycles", InReady);
        end
        A = a; B = b; Cin = cin; Sub = sub; InValid = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        InValid = 1'b0;
        A = {$urandom, $urandom};
        B = {$urandom, $urandom};
        Sub = ~sub;
        Cin = ~cin;
    endtask

    task automatic collect(input int hold, output int lat);
        logic         got, bad;
        logic [W-1:0] snap;
        exp_t         e;
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 50 && !got; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (OutValid) begin
                got = 1'b1;
                lat = k;
            end
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL out_timeout: OutValid=%b required 1 within 50 cycles", OutValid);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            if (hold > 0) begin
                snap = Sum;
                bad  = 1'b0;
                for (int k = 0; k < hold; k++) begin
                    if (Sum !== snap || OutValid !== 1'b1 || InReady !== 1'b0) bad = 1'b1;
                    if (k == 3) begin
                        InValid = 1'b1;
                        A = ~snap;
                        B = 64'h1;
                    end
                    if (k == 4) InValid = 1'b0;
                    @(negedge clk);
                end
                tests_run++;
                if (bad) begin
                    tests_failed++;
                    $display("FAIL backpressure_hold: Sum=%h OutValid=%b InReady=%b required Sum=%h OutValid=1 InReady=0",
                             Sum, OutValid, InReady, snap);
                end
            end
            e = sb.pop_front();
            tests_run++;
            if (Sum !== e.sum || Cout !== e.cout || Overflow !== e.ovf) begin
                tests_failed++;
                $display("FAIL result: Sum=%h Cout=%b Ovf=%b required Sum=%h Cout=%b Ovf=%b",
                         Sum, Cout, Overflow, e.sum, e.cout, e.ovf);
            end
            OutReady = 1'b1;
            @(posedge clk);
            #1;
            OutReady = 1'b0;
            @(negedge clk);
            tests_run++;
            if (OutValid !== 1'b0 || InReady !== 1'b1 || Busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL after_handshake: OutValid=%b InReady=%b Busy=%b required 0 1 0",
                         OutValid, InReady, Busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (InReady !== 1'b1 || OutValid !== 1'b0 || Busy !== 1'b0 ||
            Sum !== '0 || Cout !== 1'b0 || Overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: InReady=%b OutValid=%b Busy=%b Sum=%h Cout=%b Ovf=%b required 1 0 0 0 0 0",
                     InReady, OutValid, Busy, Sum, Cout, Overflow);
        end
    endtask

    task automatic test_add_basic();
        exp_t e;
        int   lat;
        e.sum = 64'h0000_0000_0001_0000; e.cout = 1'b0; e.ovf = 1'b0;
        send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, e);
        @(negedge clk);
        tests_run++;
        if (InReady !== 1'b0 || Busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL run_flags: InReady=%b Busy=%b required 0 1", InReady, Busy);
        end
        collect(0, lat);
        tests_run++;
        if (lat !== WORDS) begin
            tests_failed++;
            $display("FAIL latency: %0d cycles required %0d", lat, WORDS);
        end
    endtask

    task automatic test_carry_ripple();
        exp_t e;
        int   lat;
        e.sum = 64'h0; e.cout = 1'b1; e.ovf = 1'b0;
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, e);
        collect(0, lat);
    endtask

    task automatic test_subtract();
        exp_t e;
        int   lat;
        e.sum = 64'hFFFF_FFFF_FFFF_FFFE; e.cout = 1'b0; e.ovf = 1'b0;
        send(64'h5, 64'h7, 1'b1, 1'b1, e);
        collect(0, lat);
    endtask

    task automatic test_overflow();
        exp_t e;
        int   lat;
        e.sum = 64'h8000_0000_0000_0000; e.cout = 1'b0; e.ovf = 1'b1;
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, e);
        collect(0, lat);
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        e = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
        send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, e);
        collect(10, lat);
        e.sum = 64'h0000_0001_0000_0000; e.cout = 1'b0; e.ovf = 1'b0;
        send(64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 1'b0, e);
        collect(0, lat);
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        int   lat;
        e = model(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5556, 1'b0, 1'b0);
        send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5556, 1'b0, 1'b0, e);
        @(posedge clk);
        #1;
        rst = 1'b1;
        void'(sb.pop_back());
        #1;
        tests_run++;
        if (InReady !== 1'b1 || OutValid !== 1'b0 || Busy !== 1'b0 ||
            Sum !== '0 || Cout !== 1'b0 || Overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_run_reset: InReady=%b OutValid=%b Busy=%b Sum=%h Cout=%b Ovf=%b required 1 0 0 0 0 0",
                     InReady, OutValid, Busy, Sum, Cout, Overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        e.sum = 64'h7; e.cout = 1'b0; e.ovf = 1'b0;
        send(64'h3, 64'h4, 1'b0, 1'b0, e);
        collect(0, lat);
    endtask

    task automatic test_random();
        exp_t         e;
        int           lat;
        logic [W-1:0] a, b;
        logic         cin, sub;
        for (int i = 0; i < 6; i++) begin
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            cin = 1'($urandom_range(0, 1));
            sub = 1'(i % 2);
            e   = model(a, b, cin, sub);
            send(a, b, cin, sub, e);
            collect(0, lat);
            tests_run++;
            if (lat !== WORDS) begin
                tests_failed++;
                $display("FAIL random_latency: %0d cycles required %0d", lat, WORDS);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_basic();
        test_carry_ripple();
        test_subtract();
        test_overflow();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
